// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: FSM encodings and counter sizing helper shared by mem_burst_responder files
package mem_resp_pkg;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_LAT  = 3'd1;
    localparam state_t S_BEAT = 3'd2;
    localparam state_t S_GAP  = 3'd3;
    localparam state_t S_DONE = 3'd4;
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: 1R1W synchronous-read, read-first word RAM with resettable read register
module mem_resp_ram #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_q, rd_d;
    always_comb rd_d = re ? mem[ra] : rd_q;
    always_ff @(posedge clk) if (we) mem[wa] <= wd;
    always_ff @(posedge clk) rd_q <= rst ? '0 : rd_d;
    assign rd = rd_q;
endmodule

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: line-refill responder; define MEM_RESP_CRIT_WORD_FIRST_EN for critical-word-first beat order
module mem_burst_responder
    import mem_resp_pkg::*;
#(
    parameter int ADR_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_OFFSET    = 2,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int LATENCY        = 3,
    parameter int GAP            = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_cc2mem,
    input  logic [ADR_WIDTH-1:0]      adr_cc2mem,
    output logic                      ack_mem2cc,
    output logic [DATA_WIDTH-1:0]     dat_mem2cc,
    output logic [WORD_OFFSET-1:0]    word_mem2cc,
    input  logic                      ld_en,
    input  logic [MEM_DEPTH_LOG2-1:0] ld_adr,
    input  logic [DATA_WIDTH-1:0]     ld_dat
);
    localparam int BO    = $clog2(DATA_WIDTH / 8);
    localparam int BEATS = 2**WORD_OFFSET;
    localparam int LW    = cnt_w(LATENCY + 1);
    localparam int GW    = cnt_w(GAP + 1);
    localparam int MD    = MEM_DEPTH_LOG2;
    localparam int WO    = WORD_OFFSET;
`ifdef MEM_RESP_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    state_t            state_q, state_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [WO:0]       cnt_q, cnt_d;
    logic [MD-WO-1:0]  line_q, line_d;
    logic [WO-1:0]     start_q, start_d, word_q, word_d, issue_w;
    logic [MD-1:0]     idx;
    logic              rd_en;
    logic              unused_adr;
    assign idx        = adr_cc2mem[BO +: MD];
    assign unused_adr = ^{adr_cc2mem[ADR_WIDTH-1:BO+MD], adr_cc2mem[BO-1:0]};
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        start_d = start_q;
        word_d  = word_q;
        issue_w = start_q + cnt_q[WO-1:0];
        case (state_q)
            S_IDLE: if (req_cc2mem) begin
                state_d = S_LAT;
                lat_d   = LW'(LATENCY - 1);
                cnt_d   = '0;
                line_d  = idx[MD-1:WO];
                start_d = CWF ? idx[WO-1:0] : '0;
            end
            S_LAT:  if (lat_q == '0) state_d = S_BEAT; else lat_d = lat_q - LW'(1);
            S_BEAT: if (cnt_q == (WO+1)'(BEATS)) state_d = S_DONE;
                    else if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GW'(GAP - 1);
                    end
            S_GAP:  if (gap_q == '0) state_d = S_BEAT; else gap_d = gap_q - GW'(1);
            S_DONE: if (!req_cc2mem) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // the RAM read for a beat is launched on the edge that enters BEAT
        rd_en = (state_d == S_BEAT);
        if (rd_en) begin
            cnt_d  = cnt_q + (WO+1)'(1);
            word_d = issue_w;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
            start_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            start_q <= start_d;
            word_q  <= word_d;
        end
    end
    mem_resp_ram #(.DW(DATA_WIDTH), .AW(MD)) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (ld_en),
        .wa  (ld_adr),
        .wd  (ld_dat),
        .re  (rd_en),
        .ra  ({line_q, issue_w}),
        .rd  (dat_mem2cc)
    );
    assign ack_mem2cc  = (state_q == S_BEAT);
    assign word_mem2cc = word_q;
endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: scoreboard bench; u0 uses LATENCY=3/GAP=1, u1 uses LATENCY=1/GAP=0
module tb_mem_burst_responder;
    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic [1:0]  w;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] adr0 = '0, adr1 = '0;
    logic        ack0, ack1;
    logic [31:0] dat0, dat1;
    logic [1:0]  word0, word1;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_adr = '0;
    logic [31:0] ld_dat = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q0[$], q1[$];
    logic [31:0] a_dat[4], b_dat[4], e_dat[4];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    mem_burst_responder u0 (
        .clk(clk), .rst(rst), .req_cc2mem(req0), .adr_cc2mem(adr0),
        .ack_mem2cc(ack0), .dat_mem2cc(dat0), .word_mem2cc(word0),
        .ld_en(ld_en), .ld_adr(ld_adr), .ld_dat(ld_dat)
    );
    mem_burst_responder #(.LATENCY(1), .GAP(0)) u1 (
        .clk(clk), .rst(rst), .req_cc2mem(req1), .adr_cc2mem(adr1),
        .ack_mem2cc(ack1), .dat_mem2cc(dat1), .word_mem2cc(word1),
        .ld_en(ld_en), .ld_adr(ld_adr), .ld_dat(ld_dat)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    function automatic logic [1:0] start_of(input logic [31:0] adr);
`ifdef MEM_RESP_CRIT_WORD_FIRST_EN
        return adr[3:2];
`else
        return 2'd0;
`endif
    endfunction
    task automatic push_burst(input int dut, input int t, input int lat, input int gap,
                              input logic [31:0] adr, input logic [31:0] d[4], input int nb);
        logic [1:0] w;
        for (int k = 0; k < nb; k++) begin
            exp_t e;
            w     = start_of(adr) + 2'(k);
            e.cyc = t + lat + k * (gap + 1);
            e.d   = d[w];
            e.w   = w;
            if (dut == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask
    task automatic load(input logic [9:0] a, input logic [31:0] d);
        ld_en  = 1'b1;
        ld_adr = a;
        ld_dat = d;
        tick(1);
        ld_en  = 1'b0;
    endtask
    always @(negedge clk) if (ack0) begin
        exp_t e;
        if (q0.size() == 0) begin
            total++;
            bad++;
            $display("FAIL u0_extra_ack: got ack at cyc %0d want none", cyc);
        end else begin
            e = q0.pop_front();
            check("u0_ack_cyc", cyc, e.cyc);
            check("u0_dat", dat0, e.d);
            check("u0_word", {30'd0, word0}, {30'd0, e.w});
        end
    end
    always @(negedge clk) if (ack1) begin
        exp_t e;
        if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL u1_extra_ack: got ack at cyc %0d want none", cyc);
        end else begin
            e = q1.pop_front();
            check("u1_ack_cyc", cyc, e.cyc);
            check("u1_dat", dat1, e.d);
            check("u1_word", {30'd0, word1}, {30'd0, e.w});
        end
    end
    initial begin
        logic [1:0] w2, w3;
        for (int i = 0; i < 4; i++) begin
            a_dat[i] = 32'hA000_00A0 + i;
            b_dat[i] = 32'hB000_00B0 + i;
        end
        tick(2);
        rst = 1'b0;
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_dat0", dat0, 32'd0);
        check("rst_word0", {30'd0, word0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        check("rst_dat1", dat1, 32'd0);
        check("rst_word1", {30'd0, word1}, 32'd0);
        for (int i = 0; i < 4; i++) load(10'h340 + 10'(i), a_dat[i]);
        // back-to-back beats one cycle after accept
        req1 = 1'b1;
        adr1 = 32'hFF07_BD08;
        push_burst(1, cyc + 1, 1, 0, adr1, a_dat, 4);
        tick(8);
        req1 = 1'b0;
        tick(2);
        // gapped burst; address changes after accept must be ignored
        req0 = 1'b1;
        adr0 = 32'hFF07_BD08;
        push_burst(0, cyc + 1, 3, 1, adr0, a_dat, 4);
        tick(1);
        adr0 = 32'h0000_0000;
        tick(19);
        for (int i = 0; i < 4; i++) load(10'h340 + 10'(i), b_dat[i]);
        req0 = 1'b0;
        tick(1);
        req0 = 1'b1;
        adr0 = 32'hA555_2D08;
        push_burst(0, cyc + 1, 3, 1, adr0, b_dat, 4);
        tick(1);
        adr0 = 32'h0000_0010;
        tick(14);
        req0 = 1'b0;
        tick(2);
        // reset after the second beat discards the burst; held req restarts it
        req0 = 1'b1;
        adr0 = 32'hFF07_BD08;
        push_burst(0, cyc + 1, 3, 1, adr0, b_dat, 2);
        tick(6);
        rst = 1'b1;
        tick(1);
        check("midrst_ack0", {31'd0, ack0}, 32'd0);
        check("midrst_dat0", dat0, 32'd0);
        check("midrst_word0", {30'd0, word0}, 32'd0);
        rst = 1'b0;
        push_burst(0, cyc + 1, 3, 1, adr0, b_dat, 4);
        tick(12);
        req0 = 1'b0;
        tick(2);
        // preload during a burst: later beat sees it, same-cycle read does not
        w2 = start_of(32'hFF07_BD08) + 2'd2;
        w3 = start_of(32'hFF07_BD08) + 2'd3;
        e_dat = b_dat;
        e_dat[w3] = 32'hC0DE_0003;
        req0 = 1'b1;
        push_burst(0, cyc + 1, 3, 1, adr0, e_dat, 4);
        tick(6);
        ld_en  = 1'b1;
        ld_adr = 10'h340 + 10'(w3);
        ld_dat = 32'hC0DE_0003;
        tick(1);
        ld_adr = 10'h340 + 10'(w2);
        ld_dat = 32'hD00D_0002;
        tick(1);
        ld_en = 1'b0;
        tick(8);
        req0 = 1'b0;
        tick(4);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL u0_missing_acks: got %0d pending want 0", q0.size());
        end
        total++;
        if (q1.size() != 0) begin
            bad++;
            $display("FAIL u1_missing_acks: got %0d pending want 0", q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
